// File: rtl/acm_config_loader_pkg.sv
// Shared types and widths for the ACM configuration loader.
// The state list includes VERIFY, which is only reached when ACM_READBACK_VERIFY_EN is defined.
package acm_config_loader_pkg;

  localparam int ACM_AW    = 8;
  localparam int ACM_DW    = 8;
  localparam int WRCOUNT_W = 9;
  localparam int HOLD_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_NEXT   = 3'd5
  } acm_state_e;

  // The hold timer reloads with N-1 so that HOLD lasts exactly N cycles.
  function automatic logic [HOLD_W-1:0] hold_load_value(input int hold_cycles);
    return HOLD_W'(hold_cycles - 1);
  endfunction

endpackage

// File: rtl/acm_config_loader_hold.sv
// acm_hold_timer: 4-bit down-counter that measures the ACM settle time after each write.
module acm_hold_timer
  import acm_config_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [HOLD_W-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_expired
);

  logic [HOLD_W-1:0] r_count;

  // Load wins over decrement; the counter parks at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {HOLD_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != {HOLD_W{1'b0}})) begin
      r_count <= r_count - HOLD_W'(1);
    end
  end

  assign o_expired = (r_count == {HOLD_W{1'b0}});

endmodule

// File: rtl/acm_config_loader.sv
// acm_config_loader: scans the ACM lookup table and writes each valid entry into the ACM.
// Define ACM_READBACK_VERIFY_EN to add a one-cycle readback compare after every write; ERROR flags mismatches.
module acm_config_loader
  import acm_config_loader_pkg::*;
#(
  parameter int FIRST_ADDR  = 0,
  parameter int LAST_ADDR   = 255,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 PCLK,
  input  logic                 RESET,
  input  logic                 START,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [WRCOUNT_W-1:0] WRCOUNT,
  output logic [ACM_AW-1:0]    TBL_ADDR,
  input  logic [ACM_DW-1:0]    TBL_DATA,
  input  logic                 TBL_DO,
  output logic [ACM_AW-1:0]    ACMADDR,
  output logic [ACM_DW-1:0]    ACMWDATA,
  output logic                 ACMWEN,
  input  logic                 ACMREADY,
  input  logic [ACM_DW-1:0]    ACMRDATA,
  output logic                 ERROR
);

  localparam logic [ACM_AW-1:0] FIRST_A   = ACM_AW'(FIRST_ADDR);
  localparam logic [ACM_AW-1:0] LAST_A    = ACM_AW'(LAST_ADDR);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = hold_load_value(HOLD_CYCLES);

`ifdef ACM_READBACK_VERIFY_EN
  localparam acm_state_e POST_HOLD = ST_VERIFY;
`else
  localparam acm_state_e POST_HOLD = ST_NEXT;
`endif

  acm_state_e           r_state;
  logic [ACM_AW-1:0]    r_addr;
  logic [ACM_AW-1:0]    r_acmaddr;
  logic [ACM_DW-1:0]    r_acmwdata;
  logic [WRCOUNT_W-1:0] r_wrcount;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_wen_arm;
  logic                 w_write_fire;
  logic                 w_hold_en;
  logic                 w_hold_expired;

  // The strobe is a dedicated WRITE-state flop gated by ready, so a write is
  // accepted in the very cycle ACMREADY is seen and reset kills it at once.
  assign w_write_fire = r_wen_arm & ACMREADY;
  assign w_hold_en    = (r_state == ST_HOLD);

  acm_hold_timer u_hold_timer (
    .i_clk      (PCLK),
    .i_rst      (RESET),
    .i_load     (w_write_fire),
    .i_load_val (HOLD_LOAD),
    .i_en       (w_hold_en),
    .o_expired  (w_hold_expired)
  );

`ifdef ACM_READBACK_VERIFY_EN
  logic r_error;
`endif

  // Scan sequencer: one table entry per FETCH..NEXT pass.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_addr     <= FIRST_A;
      r_acmaddr  <= {ACM_AW{1'b0}};
      r_acmwdata <= {ACM_DW{1'b0}};
      r_wrcount  <= {WRCOUNT_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wen_arm  <= 1'b0;
`ifdef ACM_READBACK_VERIFY_EN
      r_error    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_addr    <= FIRST_A;
            r_wrcount <= {WRCOUNT_W{1'b0}};
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
`ifdef ACM_READBACK_VERIFY_EN
            r_error   <= 1'b0;
`endif
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_acmaddr  <= r_addr;
          r_acmwdata <= TBL_DATA;
          if (TBL_DO) begin
            r_wen_arm <= 1'b1;
            r_state   <= ST_WRITE;
          end else begin
            r_state   <= ST_NEXT;
          end
        end
        ST_WRITE: begin
          if (ACMREADY) begin
            r_wen_arm <= 1'b0;
            r_wrcount <= r_wrcount + WRCOUNT_W'(1);
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_hold_expired) begin
            r_state <= POST_HOLD;
          end
        end
`ifdef ACM_READBACK_VERIFY_EN
        ST_VERIFY: begin
          if (ACMRDATA != r_acmwdata) begin
            r_error <= 1'b1;
          end
          r_state <= ST_NEXT;
        end
`endif
        ST_NEXT: begin
          // Compare before incrementing so LAST_ADDR=255 never wraps.
          if (r_addr == LAST_A) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_addr  <= r_addr + ACM_AW'(1);
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_wen_arm <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ACM_READBACK_VERIFY_EN
  assign ERROR = r_error;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^ACMRDATA;
  assign ERROR          = 1'b0;
`endif

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign WRCOUNT  = r_wrcount;
  assign TBL_ADDR = r_addr;
  assign ACMADDR  = r_acmaddr;
  assign ACMWDATA = r_acmwdata;
  assign ACMWEN   = w_write_fire;

endmodule

// File: tb/tb_acm_config_loader.sv
// Directed bench for acm_config_loader: full scans, ready stall, single-entry scan,
// mid-scan reset, ignored START, all-invalid table and readback error behaviour.
module tb_acm_config_loader;

`ifdef ACM_READBACK_VERIFY_EN
  localparam int VB = 1;
`else
  localparam int VB = 0;
`endif
  localparam int VALID_C = 3 + 2 + VB;
  localparam int FULL_C  = 255 * VALID_C + 2;

  logic       PCLK;
  logic       rst;
  logic       start0, busy0, done0, tbl_do0, acmwen0, ready0, error0;
  logic [8:0] wrcount0;
  logic [7:0] tbl_addr0, tbl_data0, acmaddr0, acmwdata0, rdata0;
  logic       start1, busy1, done1, tbl_do1, acmwen1, ready1, error1;
  logic [8:0] wrcount1;
  logic [7:0] tbl_addr1, tbl_data1, acmaddr1, acmwdata1, rdata1;

  logic       all_invalid, bad7, stall_en;
  int         stall_cnt;
  logic [7:0] acm_mem0 [0:255];
  logic [7:0] acm_mem1 [0:255];

  int n_vec = 0;
  int n_bad = 0;

  acm_config_loader #(.FIRST_ADDR(0), .LAST_ADDR(255), .HOLD_CYCLES(2)) u_dut0 (
    .PCLK(PCLK), .RESET(rst), .START(start0), .BUSY(busy0), .DONE(done0),
    .WRCOUNT(wrcount0), .TBL_ADDR(tbl_addr0), .TBL_DATA(tbl_data0), .TBL_DO(tbl_do0),
    .ACMADDR(acmaddr0), .ACMWDATA(acmwdata0), .ACMWEN(acmwen0), .ACMREADY(ready0),
    .ACMRDATA(rdata0), .ERROR(error0)
  );

  acm_config_loader #(.FIRST_ADDR(255), .LAST_ADDR(255), .HOLD_CYCLES(2)) u_dut1 (
    .PCLK(PCLK), .RESET(rst), .START(start1), .BUSY(busy1), .DONE(done1),
    .WRCOUNT(wrcount1), .TBL_ADDR(tbl_addr1), .TBL_DATA(tbl_data1), .TBL_DO(tbl_do1),
    .ACMADDR(acmaddr1), .ACMWDATA(acmwdata1), .ACMWEN(acmwen1), .ACMREADY(ready1),
    .ACMRDATA(rdata1), .ERROR(error1)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  assign tbl_data0 = ~tbl_addr0;
  assign tbl_do0   = !all_invalid && (tbl_addr0 != 8'd100);
  assign rdata0    = (bad7 && acmaddr0 == 8'd7) ? 8'h00 : acm_mem0[acmaddr0];
  assign tbl_data1 = ~tbl_addr1;
  assign tbl_do1   = 1'b1;
  assign ready1    = 1'b1;
  assign rdata1    = acm_mem1[acmaddr1];

  always @(posedge PCLK) begin
    if (acmwen0) acm_mem0[acmaddr0] <= acmwdata0;
    if (acmwen1) acm_mem1[acmaddr1] <= acmwdata1;
  end

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ACM ready model: optional 10-cycle stall while entry 3 waits in WRITE
  initial begin
    ready0    = 1'b1;
    stall_cnt = 0;
    forever begin
      @(posedge PCLK);
      #1;
      if (stall_en && busy0 && acmaddr0 == 8'd3 && stall_cnt < 10) begin
        ready0 = 1'b0;
        stall_cnt++;
      end else begin
        ready0 = 1'b1;
        if (!stall_en) stall_cnt = 0;
      end
    end
  end

  int         pulse0 = 0, wr100 = 0, data_bad = 0, order_bad = 0;
  int         stall_seen = 0, stall_bad = 0, pulse1 = 0;
  logic [7:0] wr5_data = 8'h00, first_addr0 = 8'h00, prev_addr0 = 8'h00, last1 = 8'h00;
  logic       prev_valid0 = 1'b0;

  // Write-port monitor, sampled on the falling edge
  always @(negedge PCLK) begin
    if (acmwen0) begin
      pulse0++;
      if (acmaddr0 == 8'd100) wr100++;
      if (acmwdata0 != ~acmaddr0) data_bad++;
      if (acmaddr0 == 8'd5) wr5_data = acmwdata0;
      if (prev_valid0 && acmaddr0 <= prev_addr0) order_bad++;
      if (!prev_valid0) first_addr0 = acmaddr0;
      prev_addr0  = acmaddr0;
      prev_valid0 = 1'b1;
    end else if (!busy0) begin
      prev_valid0 = 1'b0;
    end
    if (busy0 && !ready0 && acmaddr0 == 8'd3) begin
      stall_seen++;
      if (acmwen0 || acmwdata0 != 8'hFC) stall_bad++;
    end
    if (acmwen1) begin
      pulse1++;
      last1 = acmaddr1;
    end
  end

  task automatic run_scan0(input int budget, input int poke_lo, output int cycles,
                           output logic err_at_accept);
    @(negedge PCLK);
    start0 = 1'b1;
    @(negedge PCLK);
    start0 = 1'b0;
    err_at_accept = error0;
    chk_vec("accept_busy", busy0, 1);
    chk_vec("accept_done", done0, 0);
    cycles = 0;
    while (!done0 && cycles < budget) begin
      @(posedge PCLK);
      cycles++;
      @(negedge PCLK);
      start0 = (poke_lo > 0) && (cycles >= poke_lo) && (cycles < poke_lo + 3) && !done0;
    end
    start0 = 1'b0;
    chk_vec("scan_done", done0, 1);
    chk_vec("scan_busy", busy0, 0);
  endtask

  int   cyc, snap, n;
  logic err_acc;

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    all_invalid = 1'b0; bad7 = 1'b0; stall_en = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_vec("rst_busy", busy0, 0);
    chk_vec("rst_done", done0, 0);
    chk_vec("rst_wrcount", wrcount0, 0);
    chk_vec("rst_acmwen", acmwen0, 0);
    chk_vec("rst_acmaddr", acmaddr0, 0);
    chk_vec("rst_acmwdata", acmwdata0, 0);
    chk_vec("rst_tbladdr", tbl_addr0, 0);
    chk_vec("rst_error", error0, 0);
    chk_vec("rst_tbladdr1", tbl_addr1, 8'd255);
    rst = 1'b0;
    repeat (2) @(negedge PCLK);

    // full scan with entry 100 invalid
    snap = pulse0;
    run_scan0(4000, 0, cyc, err_acc);
    chk_vec("t1_cycles", cyc, FULL_C);
    chk_vec("t1_wrcount", wrcount0, 255);
    chk_vec("t1_pulses", pulse0 - snap, 255);
    chk_vec("t1_wr100", wr100, 0);
    chk_vec("t1_addr5_data", wr5_data, 8'hFA);
    chk_vec("t1_data_bad", data_bad, 0);
    chk_vec("t1_order", order_bad, 0);
    chk_vec("t1_first", first_addr0, 0);
    chk_vec("t1_error", error0, 0);

    // ready stall at entry 3 plus START pokes while busy
    stall_en = 1'b1;
    snap = pulse0;
    run_scan0(4000, 50, cyc, err_acc);
    stall_en = 1'b0;
    chk_vec("t2_cycles", cyc, FULL_C + 10);
    chk_vec("t2_stall_seen", stall_seen, 10);
    chk_vec("t2_stall_bad", stall_bad, 0);
    chk_vec("t2_wrcount", wrcount0, 255);
    chk_vec("t2_pulses", pulse0 - snap, 255);
    chk_vec("t2_order", order_bad, 0);
    chk_vec("t2_mem3", acm_mem0[3], 8'hFC);

    // single-entry scan at address 255
    @(negedge PCLK); start1 = 1'b1;
    @(negedge PCLK); start1 = 1'b0;
    chk_vec("t3_busy", busy1, 1);
    cyc = 0;
    while (!done1 && cyc < 100) begin
      @(posedge PCLK); cyc++; @(negedge PCLK);
    end
    chk_vec("t3_cycles", cyc, VALID_C);
    chk_vec("t3_done", done1, 1);
    chk_vec("t3_wrcount", wrcount1, 1);
    repeat (5) @(negedge PCLK);
    chk_vec("t3_pulses", pulse1, 1);
    chk_vec("t3_addr", last1, 8'd255);
    chk_vec("t3_mem", acm_mem1[255], 8'h00);
    chk_vec("t3_nowrap", tbl_addr1, 8'd255);
    chk_vec("t3_idle", busy1, 0);

    // reset during HOLD of entry 40
    @(negedge PCLK); start0 = 1'b1;
    @(negedge PCLK); start0 = 1'b0;
    n = 0;
    while (!(acmwen0 && acmaddr0 == 8'd40) && n < 2000) begin
      @(negedge PCLK); n++;
    end
    chk_vec("t4_reach40", acmwen0 && acmaddr0 == 8'd40, 1);
    @(posedge PCLK);
    #2 rst = 1'b1;
    #1;
    chk_vec("t4_busy", busy0, 0);
    chk_vec("t4_done", done0, 0);
    chk_vec("t4_wrcount", wrcount0, 0);
    chk_vec("t4_acmwen", acmwen0, 0);
    chk_vec("t4_acmaddr", acmaddr0, 0);
    chk_vec("t4_acmwdata", acmwdata0, 0);
    chk_vec("t4_tbladdr", tbl_addr0, 0);
    chk_vec("t4_error", error0, 0);
    @(negedge PCLK); rst = 1'b0;
    snap = pulse0;
    repeat (6) @(negedge PCLK);
    chk_vec("t4_no_resume", busy0, 0);
    chk_vec("t4_no_pulse", pulse0 - snap, 0);
    run_scan0(4000, 0, cyc, err_acc);
    chk_vec("t4_cycles", cyc, FULL_C);
    chk_vec("t4_first", first_addr0, 0);
    chk_vec("t4_wrcount", wrcount0, 255);
    chk_vec("t4_pulses", pulse0 - snap, 255);

    // all-invalid table
    all_invalid = 1'b1;
    snap = pulse0;
    run_scan0(2000, 0, cyc, err_acc);
    all_invalid = 1'b0;
    chk_vec("t5_cycles", cyc, 512);
    chk_vec("t5_wrcount", wrcount0, 0);
    chk_vec("t5_pulses", pulse0 - snap, 0);

    // bad readback at entry 7 sets ERROR only when verify is built in
    bad7 = 1'b1;
    run_scan0(4000, 0, cyc, err_acc);
    bad7 = 1'b0;
    chk_vec("t6_error", error0, VB);
    chk_vec("t6_wrcount", wrcount0, 255);
    repeat (4) @(negedge PCLK);
    chk_vec("t6_sticky", error0, VB);
    run_scan0(4000, 0, cyc, err_acc);
    chk_vec("t6_clear_accept", err_acc, 0);
    chk_vec("t6_clear_end", error0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/acm_config_loader.md
Name: acm_config_loader

Overview:
- Sequencer that walks the ACM lookup table and writes every valid entry into the Analog Configuration MUX (ACM) over its parallel write port.
- It is the reading/consuming end of the table interface: it drives the table address, samples data and valid, and issues ACM writes with a ready handshake.
- It sits between the ACM lookup table and the ACM port and replaces ad-hoc microcode loops for power-up analog configuration.

Parameters:
- FIRST_ADDR, 0, first table address scanned (0..255).
- LAST_ADDR, 255, last table address scanned (FIRST_ADDR..255).
- HOLD_CYCLES, 2, idle cycles after each ACMWEN pulse for ACM settle (1..15).

Ports:
- PCLK  in  1  system clock; all logic is rising-edge.
- RESET  in  1  asynchronous active-high reset.
- START  in  1  one-cycle start request; sampled only in IDLE.
- BUSY  out  1  high from the cycle after START is accepted until the scan completes.
- DONE  out  1  sticky completion flag; cleared when the next START is accepted.
- WRCOUNT  out  9  number of ACM writes issued in the current or last scan (0..256).
- TBL_ADDR  out  8  table address; the table answers combinationally.
- TBL_DATA  in  8  table data.
- TBL_DO  in  1  table entry valid; 0 means skip this address.
- ACMADDR  out  8  ACM register address.
- ACMWDATA  out  8  ACM write data.
- ACMWEN  out  1  one-cycle write strobe.
- ACMREADY  in  1  ACM can accept a write.
- ACMRDATA  in  8  ACM readback data; used only with the optional feature.
- ERROR  out  1  sticky readback mismatch; tied 0 without the optional feature.

Behaviour:
- Reset values: state IDLE; BUSY=0, DONE=0, WRCOUNT=0, ERROR=0, ACMWEN=0, ACMADDR=0, ACMWDATA=0, TBL_ADDR=FIRST_ADDR.
- Reset asserted mid-scan aborts immediately. No ACMWEN glitch is permitted, and nothing resumes after reset.
- States: IDLE, FETCH, WRITE, HOLD, (VERIFY), NEXT.
- IDLE:
  - On START=1: load addr=FIRST_ADDR, clear WRCOUNT/DONE/ERROR, set BUSY, go to FETCH.
  - START in any other state is ignored.
- FETCH:
  - Register TBL_DATA into ACMWDATA and TBL_ADDR into ACMADDR.
  - If TBL_DO=1, go to WRITE; otherwise go to NEXT.
- WRITE:
  - Wait while ACMREADY=0, with ACMWEN=0.
  - When ACMREADY=1, ACMWEN=1 for exactly that cycle, WRCOUNT increments, go to HOLD.
- HOLD:
  - Count HOLD_CYCLES cycles with ACMWEN=0.
  - ACMADDR and ACMWDATA stay stable from FETCH through the end of HOLD.
  - Then go to VERIFY if the feature is compiled in, otherwise NEXT.
- NEXT:
  - If addr==LAST_ADDR: BUSY=0, DONE=1, go to IDLE.
  - Otherwise addr+1, go to FETCH.
  - The compare happens before the increment, so LAST_ADDR=255 never wraps to 0.
- Latency:
  - Valid entry with ACMREADY held high: 3+HOLD_CYCLES cycles (4+HOLD_CYCLES with verify).
  - Skipped entry: 2 cycles.
  - Full 256-entry all-valid scan, HOLD_CYCLES=2, no verify: 1280 cycles from accept to DONE.
- FIRST_ADDR==LAST_ADDR scans exactly one entry.
- An all-invalid table completes with WRCOUNT=0 and DONE=1.
- WRCOUNT is 9 bits so that 256 writes do not wrap.

Optional Feature:
- Macro: ACM_READBACK_VERIFY_EN.
- With the macro:
  - VERIFY state, one cycle: ACMADDR held, ACMWEN=0, ACMRDATA compared with ACMWDATA.
  - On mismatch, ERROR is set (sticky until next START). The scan continues to completion.
- Without the macro: no VERIFY state, ACMRDATA unused, ERROR constant 0.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, FETCH=1, WRITE=2, HOLD=3, VERIFY=4, NEXT=5);
  - ACM address and data width constants (8);
  - WRCOUNT width (9).
- One natural sub-module, acm_hold_timer: 4-bit down-counter with load and expire outputs, used by HOLD.

Test Plan:
1. Table returns data=~addr with DO=1 except addr 100 (DO=0); ACMREADY=1; START -> 255 ACMWEN pulses, no write at addr 100, addr 5 written with 0xFA, WRCOUNT=255, DONE=1, BUSY=0.
2. ACMREADY low for 10 cycles at addr 3 -> ACMWEN held 0 for those cycles; exactly one pulse at addr 3 once ready; ACMADDR/ACMWDATA stable throughout.
3. FIRST_ADDR=LAST_ADDR=255, DO=1 -> one write to addr 255, DONE after 3+HOLD_CYCLES cycles, no wrap to addr 0.
4. RESET asserted during HOLD of addr 40 -> all outputs return to reset values asynchronously; new START rescans from FIRST_ADDR with WRCOUNT restarting at 0.
5. START pulsed while BUSY -> ignored; WRCOUNT and scan sequence unchanged.
6. With ACM_READBACK_VERIFY_EN, ACMRDATA forced to 0x00 at addr 7 -> ERROR=1 and stays set; scan still completes with DONE=1; next START clears ERROR.
